// File: rtl/eth_tx_scheduler.sv
// ============================================================================
// Module   : eth_tx_scheduler
// Brief    : Two-requester round-robin Ethernet TX framer (preamble, SFD,
//            payload, optional pad, IFG). Padding enabled by ETH_TX_SCHED_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_scheduler #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12,
   parameter int MIN_PAYLOAD    = 60,
   parameter int LEN_W          = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   input  logic        req0_last,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   input  logic        req1_last,
   output logic        req1_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_frame,
   output logic [1:0]  grant,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_SFD      = 3'd2,
      S_PAYLOAD  = 3'd3,
      S_PAD      = 3'd4,
      S_IFG      = 3'd5
   } state_t;

   localparam logic [7:0] c_pre_last = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0] c_ifg_last = 8'(IFG_BYTES - 1);

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_grant, w_grant_nxt;
   logic        r_last_grant, w_last_grant_nxt;   // 1 means ch1 was served last
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [15:0] r_frame_cnt, w_frame_cnt_nxt;

   logic        w_sel_valid;
   logic [7:0]  w_sel_data;
   logic        w_sel_last;

`ifdef ETH_TX_SCHED_PAD_EN
   localparam logic [LEN_W-1:0] c_min_len = LEN_W'(MIN_PAYLOAD);
   logic [LEN_W-1:0] r_len, w_len_nxt, w_len_inc;
   assign w_len_inc = (&r_len) ? r_len : r_len + 1'b1;
`endif

   assign w_sel_valid = r_grant[1] ? req1_valid : req0_valid;
   assign w_sel_data  = r_grant[1] ? req1_data  : req0_data;
   assign w_sel_last  = r_grant[1] ? req1_last  : req0_last;

   assign grant     = r_grant;
   assign busy      = (r_state != S_IDLE);
   assign frame_cnt = r_frame_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_grant      <= 2'b00;
         r_last_grant <= 1'b1;
         r_cnt        <= 8'd0;
         r_frame_cnt  <= 16'd0;
`ifdef ETH_TX_SCHED_PAD_EN
         r_len        <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
         r_frame_cnt  <= w_frame_cnt_nxt;
`ifdef ETH_TX_SCHED_PAD_EN
         r_len        <= w_len_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      w_frame_cnt_nxt  = r_frame_cnt;
`ifdef ETH_TX_SCHED_PAD_EN
      w_len_nxt        = r_len;
`endif
      tx_data    = 8'h00;
      tx_valid   = 1'b0;
      tx_frame   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               // On a tie, serve the channel that was not served last
               if (req0_valid && req1_valid)
                  w_grant_nxt = r_last_grant ? 2'b01 : 2'b10;
               else
                  w_grant_nxt = req0_valid ? 2'b01 : 2'b10;
               w_last_grant_nxt = w_grant_nxt[1];
               w_cnt_nxt        = 8'd0;
               w_state_nxt      = S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            tx_frame = 1'b1;
            if (tx_ready) begin
               if (r_cnt == c_pre_last) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = S_SFD;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         S_SFD: begin
            tx_data  = 8'hD5;
            tx_valid = 1'b1;
            tx_frame = 1'b1;
            if (tx_ready) begin
               w_state_nxt = S_PAYLOAD;
`ifdef ETH_TX_SCHED_PAD_EN
               w_len_nxt   = '0;
`endif
            end
         end
         S_PAYLOAD: begin
            tx_data    = w_sel_data;
            tx_valid   = w_sel_valid;
            tx_frame   = 1'b1;
            req0_ready = r_grant[0] & tx_ready;
            req1_ready = r_grant[1] & tx_ready;
            if (w_sel_valid && tx_ready) begin
`ifdef ETH_TX_SCHED_PAD_EN
               w_len_nxt = w_len_inc;
               if (w_sel_last) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = (w_len_inc < c_min_len) ? S_PAD : S_IFG;
               end
`else
               if (w_sel_last) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = S_IFG;
               end
`endif
            end
         end
`ifdef ETH_TX_SCHED_PAD_EN
         S_PAD: begin
            tx_valid = 1'b1;
            tx_frame = 1'b1;
            if (tx_ready) begin
               w_len_nxt = w_len_inc;
               if (w_len_inc == c_min_len)
                  w_state_nxt = S_IFG;
            end
         end
`endif
         S_IFG: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               if (r_cnt == c_ifg_last) begin
                  w_cnt_nxt       = 8'd0;
                  w_grant_nxt     = 2'b00;
                  w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                  w_state_nxt     = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_scheduler.sv
// ============================================================================
// Module   : tb_eth_tx_scheduler
// Brief    : Scoreboard bench for eth_tx_scheduler (either pad build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_tx_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_last, req0_ready;
   logic [7:0]  req0_data;
   logic        req1_valid, req1_last, req1_ready;
   logic [7:0]  req1_data;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_frame, busy;
   logic [1:0]  grant;
   logic [15:0] frame_cnt;

   always #5 clock = ~clock;

   eth_tx_scheduler u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_frame   (tx_frame),
      .grant      (grant),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       frame;
      logic [1:0] grant;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        hs0 = 1'b0, hs1 = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic        toggle_en = 1'b0;
   int          cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pay(input logic [7:0] base, input int i);
      return base + 8'(i * 17);
   endfunction

   task automatic push_frame(input logic [1:0] g, input logic [7:0] base, input int n);
      repeat (7) sb.push_back('{data: 8'h55, frame: 1'b1, grant: g});
      sb.push_back('{data: 8'hD5, frame: 1'b1, grant: g});
      for (int i = 0; i < n; i++) sb.push_back('{data: pay(base, i), frame: 1'b1, grant: g});
`ifdef ETH_TX_SCHED_PAD_EN
      for (int i = n; i < 60; i++) sb.push_back('{data: 8'h00, frame: 1'b1, grant: g});
`endif
      repeat (12) sb.push_back('{data: 8'h00, frame: 1'b0, grant: g});
   endtask

   task automatic set_req(input int ch, input logic v, input logic [7:0] d, input logic l);
      if (ch == 0) begin
         req0_valid = v; req0_data = d; req0_last = l;
      end else begin
         req1_valid = v; req1_data = d; req1_last = l;
      end
   endtask

   // gap_at: byte index preceded by a 5-cycle valid drop; abort_at: byte index during which reset hits
   task automatic drive(input int ch, input logic [7:0] base, input int n,
                        input int gap_at, input int abort_at);
      int   wait_cyc;
      logic done;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            set_req(ch, 1'b0, 8'h00, 1'b0);
            repeat (5) begin
               #2;
               chk("gap_tx_valid", 32'(tx_valid), 32'd0);
               @(posedge clock); #1;
            end
         end
         set_req(ch, 1'b1, pay(base, i), (i == n - 1));
         if (i == abort_at) begin
            #1;
            reset_n = 1'b0;
            #1;
            chk("rst_tx_valid", 32'(tx_valid), 32'd0);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            set_req(ch, 1'b0, 8'h00, 1'b0);
            return;
         end
         wait_cyc = 0;
         done     = 1'b0;
         while (!done) begin
            @(posedge clock); #1;
            done = (ch == 0) ? hs0 : hs1;
            wait_cyc++;
            if (!done && wait_cyc > 500) begin
               chk("drv_timeout", 32'd1, 32'd0);
               set_req(ch, 1'b0, 8'h00, 1'b0);
               return;
            end
         end
      end
      set_req(ch, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 2000) begin
         @(posedge clock); #1;
         c++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         tx_ready = toggle_en ? ~tx_ready : 1'b1;
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) begin
         prev_stall = 1'b0;
         hs0 = 1'b0;
         hs1 = 1'b0;
      end else begin
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         if (prev_stall) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(prev_data));
         end
         if (grant == 2'b01)      chk("ready1_not_granted", 32'(req1_ready), 32'd0);
         else if (grant == 2'b10) chk("ready0_not_granted", 32'(req0_ready), 32'd0);
         else                     chk("ready_idle", 32'({req0_ready, req1_ready}), 32'd0);
         if (tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("tx_data", 32'(tx_data), 32'(e.data));
               chk("tx_frame", 32'(tx_frame), 32'(e.frame));
               chk("grant", 32'(grant), 32'(e.grant));
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_tx_valid", 32'(tx_valid), 32'd0);
      chk("reset_tx_data", 32'(tx_data), 32'd0);
      chk("reset_tx_frame", 32'(tx_frame), 32'd0);
      chk("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // AA BB CC from ch0
      push_frame(2'b01, 8'hAA, 3);
      drive(0, 8'hAA, 3, -1, -1);
      wait_idle();
      chk("frame_cnt_1", 32'(frame_cnt), 32'd1);

      // one-byte frame latency from request to IDLE
      push_frame(2'b10, 8'h77, 1);
      fork
         drive(1, 8'h77, 1, -1, -1);
         begin
            cyc = 0;
            do begin
               @(posedge clock); #1;
               cyc++;
            end while (busy && cyc < 300);
         end
      join
`ifdef ETH_TX_SCHED_PAD_EN
      chk("one_byte_cycles", 32'(cyc), 32'd81);
`else
      chk("one_byte_cycles", 32'(cyc), 32'd22);
`endif
      chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

      // tx_ready toggling every cycle
      toggle_en = 1'b1;
      push_frame(2'b01, 8'h11, 5);
      drive(0, 8'h11, 5, -1, -1);
      wait_idle();
      toggle_en = 1'b0;
      chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

      // requester drops valid mid-payload
      @(posedge clock); #1;
      push_frame(2'b10, 8'h05, 6);
      drive(1, 8'h05, 6, 3, -1);
      wait_idle();
      chk("frame_cnt_4", 32'(frame_cnt), 32'd4);

      // 60-byte payload needs no pad
      push_frame(2'b01, 8'h00, 60);
      drive(0, 8'h00, 60, -1, -1);
      wait_idle();
      chk("frame_cnt_5", 32'(frame_cnt), 32'd5);
      chk("sb_empty_a", 32'(sb.size()), 32'd0);

      // both requesters valid from reset: ch0, ch1, ch0, ch1
      reset_n = 1'b0;
      #1;
      chk("frame_cnt_cleared", 32'(frame_cnt), 32'd0);
      push_frame(2'b01, 8'h10, 4);
      push_frame(2'b10, 8'h20, 4);
      push_frame(2'b01, 8'h30, 4);
      push_frame(2'b10, 8'h40, 4);
      fork
         begin
            drive(0, 8'h10, 4, -1, -1);
            drive(0, 8'h30, 4, -1, -1);
         end
         begin
            drive(1, 8'h20, 4, -1, -1);
            drive(1, 8'h40, 4, -1, -1);
         end
         begin
            repeat (2) @(posedge clock);
            #1 reset_n = 1'b1;
         end
      join
      wait_idle();
      chk("frame_cnt_rr", 32'(frame_cnt), 32'd4);
      chk("sb_empty_b", 32'(sb.size()), 32'd0);

      // reset during the third payload byte, then a clean frame
      push_frame(2'b01, 8'h21, 6);
      drive(0, 8'h21, 6, -1, 2);
      sb.delete();
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      chk("frame_cnt_after_abort", 32'(frame_cnt), 32'd0);
      push_frame(2'b01, 8'h31, 2);
      drive(0, 8'h31, 2, -1, -1);
      wait_idle();
      chk("frame_cnt_post_abort", 32'(frame_cnt), 32'd1);
      chk("sb_empty_c", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/eth_tx_scheduler.md
# eth_tx_scheduler

Two-requester Ethernet transmit scheduler that owns the SGMII-side byte serializer. It arbitrates whole frames round-robin between two byte-stream sources and wraps each frame as 7×0x55 preamble, 0xD5 SFD, payload, optional zero padding, and an inter-frame gap of 0x00 bytes. It sits between the packet builders (XVC reply path, ARP/ICMP responder) and the bit serializer that drives `sgmii_tx_p/n`.

## Interface
- `PREAMBLE_BYTES`, 7: number of 0x55 bytes before the SFD.
- `IFG_BYTES`, 12: number of 0x00 gap bytes after each frame; legal range is 1..255.
- `MIN_PAYLOAD`, 60: minimum payload length when padding is compiled in.
- `LEN_W`, 16: payload byte counter width.
- `clock` in 1: single clock; every register is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: requester has a payload byte.
- `req0_data`, `req1_data` in 8: payload byte.
- `req0_last`, `req1_last` in 1: the current byte is the final payload byte.
- `req0_ready`, `req1_ready` out 1: the byte is consumed when ready and valid are both high.
- `tx_data` out 8: byte to the serializer.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the serializer accepts the byte. A handshake is `tx_valid && tx_ready`.
- `tx_frame` out 1: high for preamble, SFD, payload and pad bytes; low for IFG bytes.
- `grant` out 2: one-hot owner of the current frame; 0 when idle.
- `busy` out 1: the state is not IDLE.
- `frame_cnt` out 16: count of completed frames; wraps at 0xFFFF to 0.

## Operation
- States are IDLE, PREAMBLE, SFD, PAYLOAD, PAD, IFG.
- **IDLE**
  - `tx_valid` = 0 and both `reqN_ready` = 0.
  - If any `reqN_valid` is high: set `grant`, store it in `last_grant`, and go to PREAMBLE.
  - If both are valid, grant the channel that is not `last_grant`. `last_grant` resets to ch1, so ch0 wins the first tie.
- **PREAMBLE**
  - `tx_data` = 0x55, `tx_valid` = 1, `tx_frame` = 1.
  - After `PREAMBLE_BYTES` handshakes, go to SFD.
- **SFD**
  - `tx_data` = 0xD5.
  - After one handshake, go to PAYLOAD and clear the length counter.
- **PAYLOAD** is a combinational pass-through from the granted channel:
  - `tx_data` = `reqG_data`.
  - `tx_valid` = `reqG_valid`.
  - `reqG_ready` = `tx_ready`.
  - The non-granted channel's ready stays 0.
  - Each handshake increments the length counter, which saturates at 2^LEN_W−1.
  - A handshake with `reqG_last` = 1 ends the payload and selects the next state; see Configuration.
- **PAD**
  - `tx_data` = 0x00, `tx_frame` = 1.
  - Leave when the length counter equals `MIN_PAYLOAD`.
- **IFG**
  - `tx_data` = 0x00, `tx_valid` = 1, `tx_frame` = 0.
  - After `IFG_BYTES` handshakes, go to IDLE, clear `grant`, and increment `frame_cnt`.
- A requester that raises valid mid-frame waits and is not starved: it wins the next IDLE decision if the other channel was last served.
- **Reset**
  - Asynchronous assertion returns the block to IDLE immediately and abandons any frame in flight; no IFG is sent.
  - Reset values: `tx_valid`=0, `tx_data`=0x00, `tx_frame`=0, `req0_ready`=`req1_ready`=0, `grant`=0, `busy`=0, `frame_cnt`=0, `last_grant`=ch1, all counters 0.

## Timing
- IDLE→PREAMBLE takes one cycle. The first 0x55 has `tx_valid` high on the cycle after `reqN_valid` is sampled.
- State and counters advance only on handshakes. `tx_ready` low stalls with all outputs held stable; a valid byte never changes while unaccepted.
- PREAMBLE, SFD, PAD and IFG bytes have zero extra latency between handshakes. With `tx_ready` held high, a one-byte frame with no pad takes 1 + 7 + 1 + 1 + `IFG_BYTES` cycles from request to IDLE.
- In PAYLOAD, `reqG_valid` low gives `tx_valid` low; the block neither inserts bytes nor aborts.
- After the last IFG byte there is one IDLE cycle before a new grant can be issued.
- `frame_cnt` updates on the cycle the state enters IDLE from IFG.

## Configuration
- `ETH_TX_SCHED_PAD_EN` defined:
  - After the last payload handshake, go to PAD if the length counter is below `MIN_PAYLOAD`, otherwise go to IFG.
  - PAD emits exactly (`MIN_PAYLOAD` − length) bytes of 0x00.
- `ETH_TX_SCHED_PAD_EN` undefined:
  - PAD is unreachable; the last payload handshake always goes to IFG.
  - No pad logic is synthesized.

## Test plan
- Reset, then ch0 sends 3 bytes AA BB CC (last on CC) with `tx_ready`=1 -> `tx_data` is 55×7, D5, AA BB CC. With PAD_EN, 57 bytes of 00 follow with `tx_frame`=1. Then 12 bytes of 00 with `tx_frame`=0, and `frame_cnt`=1.
- Both requesters are valid from reset, and each sends 2 frames of 4 bytes -> grant order is ch0, ch1, ch0, ch1. The non-granted ready stays 0 throughout, and `frame_cnt`=4.
- `tx_ready` toggles 0/1 every cycle through a whole frame -> the byte sequence is identical to the ungapped case, and `tx_data` is stable during every stalled cycle.
- Requester drops `req0_valid` for 5 cycles mid-payload -> `tx_valid`=0 for those 5 cycles, no bytes are inserted, and the frame resumes correctly.
- `reset_n` is asserted during the third payload byte -> in the same cycle (before the next clock edge) the state is IDLE and `tx_valid`, `grant`, `busy` and the ready outputs are 0. `frame_cnt` is 0 afterwards, and the next frame begins with a full preamble.
- A 60-byte payload with PAD_EN -> no PAD bytes are emitted, and IFG follows directly.
